vector_frame_sched: RTL and testbench
=====================================

# vector_frame_sched

Frame scheduler sitting in front of `top_vector_display`. It sequences the display engine frame by frame via the `go_master`/`halt` handshake and enforces a fixed frame period (refresh rate). It selects which scene of the shared vector ROM is drawn by offsetting the engine's frame-relative address with a per-scene base. It also flags frames that overrun the period.

## Interface
Parameters:
- `ADDRESSWIDTH`, default `vector_pkg::ADDRESSWIDTH`: ROM address width.
- `NUM_SCENES`, default 4: number of scenes in ROM.
- `FRAME_PERIOD`, default 1_000_000: clk cycles from frame start to next frame start; must be ≥ 2.
- `WDOG_CYCLES`, default 4_000_000: draw timeout; used only with the watchdog macro.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; enables frame scheduling.
- `scene_req`  in  SCENE_W  requested scene; sampled only at frame start.
- `go_master`  out  1  to engine; high for the whole draw of a frame.
- `halt`  in  1  from engine; frame-drawn pulse.
- `disp_addr`  in  ADDRESSWIDTH  engine's frame-relative address.
- `rom_addr`  out  ADDRESSWIDTH  address to ROM.
- `scene_active`  out  SCENE_W  scene being drawn.
- `frame_done`  out  1  one-cycle pulse per completed frame.
- `frame_cnt`  out  16  completed frames; wraps at 2^16.
- `busy`  out  1  state ≠ IDLE.
- `overrun`  out  1  sticky: some frame exceeded FRAME_PERIOD.
- `fault`  out  1  sticky: watchdog abort.

## Operation
- States: IDLE, DRAW, HOLD.
- Reset values: IDLE; `go_master`, `frame_done`, `busy`, `overrun`, `fault` = 0; `scene_active` = 0; `frame_cnt` = 0; period counter = 0.
- IDLE: when `run`=1, latch the scene, clear the period counter, and set `go_master`←1. Go to DRAW.
- Scene latch: `scene_active`←`scene_req`. A value ≥ NUM_SCENES clamps to NUM_SCENES-1.
- DRAW: the period counter increments each cycle and saturates at its maximum.
  - On `halt`=1: `go_master`←0, `frame_done`←1 for one cycle, `frame_cnt`++. Go to HOLD.
  - If the counter reaches FRAME_PERIOD-1 while still in DRAW: `overrun`←1. The draw continues.
- HOLD: the counter keeps incrementing. Exit when counter ≥ FRAME_PERIOD-1:
  - `run`=1: latch the scene, clear the counter, `go_master`←1, go to DRAW.
  - `run`=0: go to IDLE.
- `run` dropping mid-DRAW does not abort. The frame finishes, then HOLD runs, then IDLE.
- `halt` in IDLE or HOLD is ignored.
- `scene_req` changes mid-frame have no effect until the next latch.
- `rom_addr` = SCENE_BASE[`scene_active`] + `disp_addr`. Combinational, truncated mod 2^ADDRESSWIDTH (wraps).
- `rst` mid-frame: all outputs return to reset values at that edge. `go_master` is low the next cycle.

## Timing
- `go_master` rises one cycle after `run` is first sampled high in IDLE.
- `go_master` falls on the edge after `halt` is sampled.
- Frame start to frame start is exactly FRAME_PERIOD cycles if `halt` arrives at counter ≤ FRAME_PERIOD-2.
- Late `halt`: HOLD lasts one cycle, so the next start comes 2 cycles after `halt`.
- `frame_done` and `frame_cnt` update in the same cycle `go_master` falls.
- `rom_addr` has zero latency from `disp_addr`, which suits the asynchronous ROM.
- `halt` coinciding with counter = FRAME_PERIOD-1: the frame completes and `overrun` is set.

## Configuration
- `VECTOR_SCHED_WATCHDOG_EN` defined:
  - In DRAW, counter = WDOG_CYCLES-1 with no `halt` causes abort: `go_master`←0, `fault`←1 (sticky), go to IDLE.
  - `frame_cnt` is unchanged and there is no `frame_done` pulse.
  - Scheduling restarts from IDLE if `run`=1.
- Undefined: `fault` is tied 0 and DRAW waits indefinitely. The counter saturates, so there is no wrap-induced false exit.

## Structure
- `vector_pkg` additions:
  - NUM_SCENES and SCENE_W = $clog2(NUM_SCENES).
  - SCENE_BASE (array of ADDRESSWIDTH constants).
  - `sched_state_t` enum {IDLE, DRAW, HOLD}.
- Sub-module `vector_sched_timer`: saturating up-counter with synchronous clear. Flags: `period_end` (≥ FRAME_PERIOD-1) and `wdog_end` (= WDOG_CYCLES-1, present only under the macro).

## Test plan
Bench parameters: FRAME_PERIOD=100, WDOG_CYCLES=300, ADDRESSWIDTH=8, SCENE_BASE={0,64,128,192}.
- Steady refresh: `run`=1 from cycle 10, engine raises `halt` 40 cycles after each `go_master` rise → `go_master` rises at 11, 111, 211. `frame_cnt` = 3 after the third `halt`. `overrun` stays 0.
- Scene switch: `scene_req`=2 mid-frame, `disp_addr`=10 → `rom_addr`=10 until the next start, then 138. `scene_req`=7 clamps to 3. `disp_addr`=70 with scene 3 wraps to 6.
- Overrun: `halt` 120 cycles after start → `overrun`=1 at counter 99. Next `go_master` rise 2 cycles after `halt`. A 40-cycle frame afterwards keeps `overrun`=1.
- Stop: `run`←0 mid-DRAW → the frame completes, HOLD runs to cycle 100 of the period, then IDLE. `busy`=0 and `go_master` stays 0.
- Reset mid-DRAW: `rst` at counter 50 → next cycle `go_master`=0, `frame_cnt`=0, `busy`=0. With `run` held high, `go_master` rises again 1 cycle after `rst` deasserts.
- Watchdog (macro defined): never raise `halt` → `go_master` falls and `fault`=1 at counter 299. `frame_cnt` unchanged. With the macro undefined, `go_master` stays high indefinitely.

Source files
------------

// File: rtl/vector_pkg.sv
// -----------------------------------------------------------------------------
// vector_pkg
//   Shared constants and types for the vector display slice.
//   - ADDRESSWIDTH : vector ROM address width
//   - NUM_SCENES   : number of scenes stored in the shared vector ROM
//   - SCENE_W      : width of a scene index
//   - SCENE_BASE   : first ROM address of each scene
//   - sched_state_t: frame scheduler states (IDLE, DRAW, HOLD)
//   - clamp_scene  : maps an out-of-range scene request onto the last scene
// -----------------------------------------------------------------------------
package vector_pkg;

    localparam int ADDRESSWIDTH = 8;
    localparam int NUM_SCENES   = 4;
    localparam int SCENE_W      = $clog2(NUM_SCENES);

    localparam logic [ADDRESSWIDTH-1:0] SCENE_BASE [NUM_SCENES] = '{
        ADDRESSWIDTH'(0),
        ADDRESSWIDTH'(64),
        ADDRESSWIDTH'(128),
        ADDRESSWIDTH'(192)
    };

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_DRAW = 2'd1,
        SCHED_HOLD = 2'd2
    } sched_state_t;

    // Requests at or beyond the scene count select the last scene instead of
    // pointing the engine into unrelated ROM contents.
    function automatic logic [SCENE_W-1:0] clamp_scene(
        input logic [SCENE_W-1:0] req,
        input int                 num
    );
        if (int'(req) >= num) begin
            return SCENE_W'(num - 1);
        end
        return req;
    endfunction

endpackage

// File: rtl/vector_sched_timer.sv
// -----------------------------------------------------------------------------
// vector_sched_timer
//   Saturating frame-period counter with synchronous clear.
//   Macro: VECTOR_SCHED_WATCHDOG_EN adds the wdog_end_o flag.
//   Ports:
//     clk_i        : system clock
//     rst_i        : synchronous active-high reset (count -> 0)
//     clr_i        : synchronous clear, wins over enable
//     en_i         : count enable
//     period_end_o : count >= FRAME_PERIOD-1
//     wdog_end_o   : count == WDOG_CYCLES-1 (watchdog build only)
// -----------------------------------------------------------------------------
module vector_sched_timer #(
    parameter int FRAME_PERIOD = 1_000_000,
    parameter int WDOG_CYCLES  = 4_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic period_end_o
`ifdef VECTOR_SCHED_WATCHDOG_EN
    ,
    output logic wdog_end_o
`endif
);

    // Wide enough for both thresholds so neither compare can be missed.
    localparam int CNT_MAX = (WDOG_CYCLES > FRAME_PERIOD) ? WDOG_CYCLES : FRAME_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturation keeps a stalled draw from wrapping back below the period
    // threshold and releasing HOLD early.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign period_end_o = (cnt_q >= CNT_W'(FRAME_PERIOD - 1));

`ifdef VECTOR_SCHED_WATCHDOG_EN
    assign wdog_end_o = (cnt_q == CNT_W'(WDOG_CYCLES - 1));
`endif

endmodule

// File: rtl/vector_frame_sched.sv
// -----------------------------------------------------------------------------
// vector_frame_sched
//   Frame scheduler in front of the vector display engine. Starts one draw per
//   frame period through go_master_o / halt_i, offsets the engine's
//   frame-relative address by the active scene's ROM base, and flags frames
//   that run past the period.
//   Macro: VECTOR_SCHED_WATCHDOG_EN enables the draw-timeout abort (fault_o).
//
//   Handshake: go_master_o is held high for the whole draw. The engine answers
//   with a one-cycle halt_i pulse when the frame is drawn; halt_i is only
//   honoured while drawing and is ignored in IDLE and HOLD.
//
//   Ports:
//     clk_i, rst_i     : clock, synchronous active-high reset
//     run_i            : level, enables frame scheduling
//     scene_req_i      : requested scene, sampled only at frame start
//     go_master_o      : draw enable to the engine
//     halt_i           : frame-drawn pulse from the engine
//     disp_addr_i      : engine frame-relative ROM address
//     rom_addr_o       : scene base + disp_addr_i (combinational, wraps)
//     scene_active_o   : scene being drawn
//     frame_done_o     : one-cycle pulse per completed frame
//     frame_cnt_o      : completed frames, wraps at 2^16
//     busy_o           : scheduler not idle
//     overrun_o        : sticky, some frame exceeded the period
//     fault_o          : sticky, watchdog abort (0 without the macro)
//     state_o          : current scheduler state (debug)
// -----------------------------------------------------------------------------
module vector_frame_sched #(
    parameter int ADDRESSWIDTH = vector_pkg::ADDRESSWIDTH,
    parameter int NUM_SCENES   = 4,
    parameter int FRAME_PERIOD = 1_000_000,
    parameter int WDOG_CYCLES  = 4_000_000
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           run_i,
    input  logic [vector_pkg::SCENE_W-1:0] scene_req_i,
    output logic                           go_master_o,
    input  logic                           halt_i,
    input  logic [ADDRESSWIDTH-1:0]        disp_addr_i,
    output logic [ADDRESSWIDTH-1:0]        rom_addr_o,
    output logic [vector_pkg::SCENE_W-1:0] scene_active_o,
    output logic                           frame_done_o,
    output logic [15:0]                    frame_cnt_o,
    output logic                           busy_o,
    output logic                           overrun_o,
    output logic                           fault_o,
    output logic [1:0]                     state_o
);

    import vector_pkg::*;

    localparam logic [1:0] ST_IDLE = SCHED_IDLE;
    localparam logic [1:0] ST_DRAW = SCHED_DRAW;
    localparam logic [1:0] ST_HOLD = SCHED_HOLD;

    logic [1:0]         state_q,   state_d;
    logic               go_q,      go_d;
    logic [SCENE_W-1:0] scene_q,   scene_d;
    logic               done_q,    done_d;
    logic [15:0]        fcnt_q,    fcnt_d;
    logic               overrun_q, overrun_d;
    logic               start;
    logic               period_end;

`ifdef VECTOR_SCHED_WATCHDOG_EN
    logic               fault_q,   fault_d;
    logic               wdog_end;
`endif

    vector_sched_timer #(
        .FRAME_PERIOD (FRAME_PERIOD),
        .WDOG_CYCLES  (WDOG_CYCLES)
    ) u_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (start),
        .en_i         (state_q != ST_IDLE),
        .period_end_o (period_end)
`ifdef VECTOR_SCHED_WATCHDOG_EN
        ,
        .wdog_end_o   (wdog_end)
`endif
    );

    always_comb begin
        state_d   = state_q;
        go_d      = go_q;
        scene_d   = scene_q;
        done_d    = 1'b0;
        fcnt_d    = fcnt_q;
        overrun_d = overrun_q;
        start     = 1'b0;
`ifdef VECTOR_SCHED_WATCHDOG_EN
        fault_d   = fault_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    start = 1'b1;
                end
            end
            ST_DRAW: begin
                // Overrun is only flagged; the draw is never cut short by it.
                if (period_end) begin
                    overrun_d = 1'b1;
                end
                if (halt_i) begin
                    go_d    = 1'b0;
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + 16'd1;
                    state_d = ST_HOLD;
                end
`ifdef VECTOR_SCHED_WATCHDOG_EN
                else if (wdog_end) begin
                    go_d    = 1'b0;
                    fault_d = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_HOLD: begin
                // run_i is only consulted once the period has elapsed, so a
                // mid-frame stop still completes the full period.
                if (period_end) begin
                    if (run_i) begin
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                go_d    = 1'b0;
            end
        endcase

        if (start) begin
            scene_d = clamp_scene(scene_req_i, NUM_SCENES);
            go_d    = 1'b1;
            state_d = ST_DRAW;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            go_q      <= 1'b0;
            scene_q   <= '0;
            done_q    <= 1'b0;
            fcnt_q    <= 16'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            go_q      <= go_d;
            scene_q   <= scene_d;
            done_q    <= done_d;
            fcnt_q    <= fcnt_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef VECTOR_SCHED_WATCHDOG_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign fault_o = fault_q;
`else
    assign fault_o = 1'b0;
`endif

    // Zero-latency offset for the asynchronous ROM; the add wraps naturally.
    assign rom_addr_o     = ADDRESSWIDTH'(SCENE_BASE[scene_q]) + disp_addr_i;
    assign go_master_o    = go_q;
    assign scene_active_o = scene_q;
    assign frame_done_o   = done_q;
    assign frame_cnt_o    = fcnt_q;
    assign overrun_o      = overrun_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign state_o        = state_q;

endmodule

// File: tb/tb_vector_frame_sched.sv
module tb_vector_frame_sched;

    localparam int AW     = 8;
    localparam int NS     = 4;
    localparam int FP     = 100;
    localparam int WD_CYC = 300;
`ifdef VECTOR_SCHED_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst, run, halt;
    logic [1:0]    scene_req;
    logic [AW-1:0] disp_addr;
    logic          go, done, busy, over, fault;
    logic [AW-1:0] rom_addr;
    logic [1:0]    scene_act, state;
    logic [15:0]   fcnt;

    always #5 clk = ~clk;

    vector_frame_sched #(
        .ADDRESSWIDTH (AW),
        .NUM_SCENES   (NS),
        .FRAME_PERIOD (FP),
        .WDOG_CYCLES  (WD_CYC)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .run_i          (run),
        .scene_req_i    (scene_req),
        .go_master_o    (go),
        .halt_i         (halt),
        .disp_addr_i    (disp_addr),
        .rom_addr_o     (rom_addr),
        .scene_active_o (scene_act),
        .frame_done_o   (done),
        .frame_cnt_o    (fcnt),
        .busy_o         (busy),
        .overrun_o      (over),
        .fault_o        (fault),
        .state_o        (state)
    );

    int total = 0;
    int bad   = 0;
    int c     = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, c, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Works in absolute edge numbers: a frame started at edge s has its
    // period boundary at edge s+FP, the watchdog fires at edge s+WD_CYC, and
    // after a halt at edge h the next start is at max(s+FP, h+1).
    localparam int P_IDLE = 0, P_DRAW = 1, P_HOLD = 2;
    int base_tab [NS] = '{0, 64, 128, 192};
    int n = 0, m_ph = P_IDLE, m_start = 0, m_next = 0, m_cnt = 0, m_scene = 0;
    bit m_go = 0, m_done = 0, m_over = 0, m_fault = 0;

    task automatic start_frame();
        m_start = n;
        m_go    = 1'b1;
        m_scene = (int'(scene_req) >= NS) ? NS - 1 : int'(scene_req);
        m_ph    = P_DRAW;
    endtask

    task automatic model_edge();
        n++;
        m_done = 1'b0;
        if (rst) begin
            m_ph = P_IDLE; m_go = 0; m_over = 0; m_fault = 0; m_cnt = 0; m_scene = 0;
        end else begin
            case (m_ph)
                P_IDLE: if (run) start_frame();
                P_DRAW: begin
                    if (n >= m_start + FP) m_over = 1'b1;
                    if (halt) begin
                        m_go   = 1'b0;
                        m_done = 1'b1;
                        m_cnt  = (m_cnt + 1) % 65536;
                        m_next = (m_start + FP > n + 1) ? m_start + FP : n + 1;
                        m_ph   = P_HOLD;
                    end else if (WD_EN && (n == m_start + WD_CYC)) begin
                        m_go    = 1'b0;
                        m_fault = 1'b1;
                        m_ph    = P_IDLE;
                    end
                end
                default: begin
                    if (n >= m_next) begin
                        if (run) start_frame();
                        else m_ph = P_IDLE;
                    end
                end
            endcase
        end
    endtask

    task automatic cmp_all();
        check("go_master", go, m_go);
        check("frame_done", done, m_done);
        check("frame_cnt", fcnt, m_cnt);
        check("busy", busy, m_ph != P_IDLE);
        check("overrun", over, m_over);
        check("fault", fault, m_fault);
        check("scene_active", scene_act, m_scene);
        check("rom_addr", rom_addr, (base_tab[m_scene] + int'(disp_addr)) % 256);
    endtask

    // One clock: sample #1 after the edge, advance the model, compare.
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        c++;
        cmp_all();
    endtask

    // ---------------- driver tasks ----------------
    int          last_rise = 0, cur_dly = -1;
    int          dly_q [$];
    logic [31:0] rise_q [$];

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; halt = 1'b0;
        step();
        rst = 1'b0;
        c = 0; cur_dly = -1; last_rise = 0;
        dly_q.delete(); rise_q.delete();
    endtask

    // Engine stand-in: after each go_master rise, pulse halt after the next
    // delay taken from dly_q (no halt at all when the queue is empty).
    task automatic advance_to(input int target);
        logic prev;
        while (c < target) begin
            halt = (cur_dly >= 0) && (c == last_rise + cur_dly);
            prev = go;
            step();
            if (go && !prev) begin
                last_rise = c;
                rise_q.push_back(c);
                cur_dly = (dly_q.size() > 0) ? dly_q.pop_front() : -1;
            end
        end
        halt = 1'b0;
    endtask

    typedef struct {
        logic [1:0]    scene;
        logic [AW-1:0] disp;
        logic [AW-1:0] exp_rom;
    } vec_t;
    vec_t        tbl [6];
    logic [31:0] exp_q [$];

    initial begin
        #500000;
        $display("FAIL timeout: simulation limit reached at cycle %0d", c);
        $fatal(1);
    end

    initial begin
        logic [31:0] r0;
        int          age, dly;
        logic        eprev;

        rst = 1'b1; run = 1'b1; halt = 1'b0; scene_req = 2'd3; disp_addr = '0;

        // Reset wins even with run asserted.
        step();
        check("rst_go", go, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", fcnt, 0);
        check("rst_scene", scene_act, 0);
        check("rst_overrun", over, 0);
        check("rst_fault", fault, 0);

        // Scene base / clamp / wrap vectors. A request of 7 is not
        // representable on the 2-bit port; 3 is the clamped result.
        tbl[0] = '{2'd2, 8'd10,  8'd138};
        tbl[1] = '{2'd3, 8'd70,  8'd6};
        tbl[2] = '{2'd0, 8'd5,   8'd5};
        tbl[3] = '{2'd1, 8'd200, 8'd8};
        tbl[4] = '{2'd3, 8'd63,  8'd255};
        tbl[5] = '{2'd1, 8'd0,   8'd64};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            run = 1'b1; scene_req = tbl[i].scene; disp_addr = tbl[i].disp;
            step();
            run = 1'b0;
            check("tbl_scene", scene_act, tbl[i].scene);
            check("tbl_rom", rom_addr, tbl[i].exp_rom);
        end

        // Steady refresh with a mid-frame scene change.
        do_reset();
        scene_req = 2'd0; disp_addr = 8'd10;
        dly_q = '{40, 40, 40};
        advance_to(10);
        run = 1'b1;
        advance_to(50);
        scene_req = 2'd2;
        advance_to(60);
        check("scene_hold_rom", rom_addr, 10);
        advance_to(111);
        check("scene_switch_rom", rom_addr, 138);
        advance_to(255);
        exp_q = '{32'd11, 32'd111, 32'd211};
        check("steady_rises", rise_q.size(), 3);
        while (exp_q.size() > 0 && rise_q.size() > 0) begin
            check("steady_rise_cycle", rise_q.pop_front(), exp_q.pop_front());
        end
        check("steady_cnt", fcnt, 3);
        check("steady_overrun", over, 0);

        // Overrun: 120-cycle frame then a 40-cycle frame.
        do_reset();
        run = 1'b1;
        dly_q = '{120, 40, 40};
        advance_to(100);
        check("ovr_before", over, 0);
        advance_to(101);
        check("ovr_set", over, 1);
        check("ovr_go_still", go, 1);
        advance_to(168);
        check("ovr_sticky", over, 1);
        advance_to(230);
        exp_q = '{32'd1, 32'd123, 32'd223};
        check("ovr_rises", rise_q.size(), 3);
        while (exp_q.size() > 0 && rise_q.size() > 0) begin
            check("ovr_rise_cycle", rise_q.pop_front(), exp_q.pop_front());
        end

        // Stop mid-draw: frame finishes, HOLD to period end, then IDLE.
        do_reset();
        run = 1'b1;
        dly_q = '{40};
        advance_to(21);
        run = 1'b0;
        advance_to(100);
        check("stop_hold_busy", busy, 1);
        check("stop_hold_go", go, 0);
        advance_to(101);
        check("stop_idle_busy", busy, 0);
        advance_to(150);
        check("stop_go", go, 0);
        check("stop_cnt", fcnt, 1);

        // Reset mid-draw at counter 50 of the second frame.
        do_reset();
        run = 1'b1;
        dly_q = '{40, 200};
        advance_to(151);
        check("mrst_pre_go", go, 1);
        check("mrst_pre_cnt", fcnt, 1);
        rst = 1'b1;
        advance_to(152);
        rst = 1'b0;
        check("mrst_go", go, 0);
        check("mrst_cnt", fcnt, 0);
        check("mrst_busy", busy, 0);
        advance_to(153);
        check("mrst_restart", go, 1);

        // Watchdog: no halt ever.
        do_reset();
        run = 1'b1;
        advance_to(300);
        check("wd_pre_go", go, 1);
        advance_to(301);
`ifdef VECTOR_SCHED_WATCHDOG_EN
        check("wd_go", go, 0);
        check("wd_fault", fault, 1);
        check("wd_cnt", fcnt, 0);
        check("wd_no_done", done, 0);
        advance_to(302);
        check("wd_restart", go, 1);
`else
        advance_to(450);
        check("nowd_go", go, 1);
        check("nowd_fault", fault, 0);
`endif

        // Randomized run against the model.
        do_reset();
        run = 1'b1; age = 0; dly = -1; eprev = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) run = ~run;
            rst       = ($urandom_range(0, 799) == 0);
            scene_req = 2'($urandom_range(0, 3));
            disp_addr = AW'($urandom);
            if (go && !eprev) begin
                age = 0;
                r0  = $urandom_range(0, 9);
                if (r0 < 7)      dly = $urandom_range(2, 97);
                else if (r0 < 9) dly = $urandom_range(98, 130);
                else             dly = 320;
            end else if (go) begin
                age++;
            end
            halt  = (go && (age == dly)) || (!go && ($urandom_range(0, 19) == 0));
            eprev = go;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
